output_write: RTL

// - Write-side counterpart of the byte field reader: assembles one 8-bit output byte from

---
 rtl/output_write_if.sv | 23 ++
 rtl/output_write.sv | 125 ++++++++++++
 2 files changed

// File: rtl/output_write_if.sv
// Request/response bundle for the field-write byte assembler: field writes and
// commits go in, committed bytes with their written-bit mask come out.
interface output_write_if;
   logic       in_valid;
   logic       in_ready;
   logic [1:0] field_sel;
   logic [7:0] field_data;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] data_out;
   logic [7:0] mask_out;
   logic       ovl_err;

   modport master (
      output in_valid, field_sel, field_data, out_ready,
      input  in_ready, out_valid, data_out, mask_out, ovl_err
   );

   modport slave (
      input  in_valid, field_sel, field_data, out_ready,
      output in_ready, out_valid, data_out, mask_out, ovl_err
   );
endinterface

// File: rtl/output_write.sv
// Assembles one byte from BIT/MID/HIGH field writes, then on COMMIT fills the
// unwritten bits, applies the selected transform and holds the byte for the consumer.
module output_write #(
   parameter int   BIT_POS = 3,
   parameter logic FILL    = 1'b0
) (
   input  logic           clk,
   input  logic           rst_n,
   output_write_if.slave  bus,
   output logic           state_dbg
);

   // Handshake: a transfer happens on a rising edge where valid && ready are both high;
   // valid and its payload are held until that edge, and ready never depends on valid.

   localparam logic [1:0] SEL_BIT    = 2'b00;
   localparam logic [1:0] SEL_MID    = 2'b01;
   localparam logic [1:0] SEL_HIGH   = 2'b10;
   localparam logic [1:0] SEL_COMMIT = 2'b11;
   localparam logic [2:0] BIT_IDX    = 3'(BIT_POS);

   typedef enum logic {
      COLLECT = 1'b0,
      OUTPUT  = 1'b1
   } state_t;

   state_t     state;
   state_t     state_nxt;
   logic [7:0] asm_byte;
   logic [7:0] asm_mask;
   logic [7:0] new_mask;
   logic [7:0] new_byte;
   logic [7:0] merged;
   logic [7:0] committed;
   logic       accept;
   logic       handshake;
   logic       unused_data;

   assign accept      = bus.in_valid && bus.in_ready;
   assign handshake   = bus.out_valid && bus.out_ready;
   assign unused_data = ^bus.field_data[7:4];

   always_ff @(posedge clk) begin
      if (!rst_n) state <= COLLECT;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         COLLECT: if (accept && bus.field_sel == SEL_COMMIT) state_nxt = OUTPUT;
         OUTPUT:  if (bus.out_ready) state_nxt = COLLECT;
         default: state_nxt = COLLECT;
      endcase
   end

   always_comb begin
      bus.in_ready  = (state == COLLECT);
      bus.out_valid = (state == OUTPUT);
      state_dbg     = state;
   end

   // Bits touched by the current field write and the values they take.
   always_comb begin
      new_mask = '0;
      new_byte = '0;
      case (bus.field_sel)
         SEL_BIT: begin
            new_mask[BIT_IDX] = 1'b1;
            new_byte[BIT_IDX] = bus.field_data[0];
         end
         SEL_MID: begin
            new_mask      = 8'h3C;
            new_byte[5:2] = bus.field_data[3:0];
         end
         SEL_HIGH: begin
            new_mask      = 8'hF0;
            new_byte[7:4] = bus.field_data[3:0];
         end
         default: ;
      endcase
   end

   assign merged = (asm_byte & asm_mask) | ({8{FILL}} & ~asm_mask);

   always_comb begin
      committed = merged;
      case (bus.field_data[1:0])
         2'b00: committed = merged;
         2'b01: committed = {merged[5:0], 2'b00};
         2'b10: committed = {4'b0000, merged[7:4]};
         default: begin
            for (int i = 0; i < 8; i++) committed[i] = merged[7 - i];
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         asm_byte     <= '0;
         asm_mask     <= '0;
         bus.data_out <= '0;
         bus.mask_out <= '0;
         bus.ovl_err  <= 1'b0;
      end else begin
         bus.ovl_err <= 1'b0;
         if (accept) begin
            if (bus.field_sel == SEL_COMMIT) begin
               bus.data_out <= committed;
               bus.mask_out <= asm_mask;
            end else begin
               asm_byte    <= (asm_byte & ~new_mask) | new_byte;
               asm_mask    <= asm_mask | new_mask;
               bus.ovl_err <= |(new_mask & asm_mask);
            end
         end
         // Next byte starts from an empty mask once the consumer takes this one.
         if (handshake) begin
            asm_byte <= '0;
            asm_mask <= '0;
         end
      end
   end

endmodule
